// File: rtl/rs_pkg.sv
// Shared field/code defaults and GF(2^M) helper functions for the
// Reed-Solomon syndrome engine.
package rs_pkg;

    localparam int         RS_M         = 4;
    localparam int         RS_N         = 15;
    localparam int         RS_T         = 1;
    localparam int         RS_FCR       = 1;
    localparam logic [4:0] RS_PRIM_POLY = 5'b10011;

    // Shift-and-add GF(2^m) product, reduced by poly; m <= 16.
    // With a constant k this collapses to a pure XOR network.
    function automatic logic [15:0] gf_mul_const(
        input logic [15:0] a,
        input logic [15:0] k,
        input int          m,
        input logic [16:0] poly
    );
        logic [16:0] x;
        logic [15:0] p;
        p = '0;
        x = {1'b0, a};
        for (int i = 0; i < 16; i++) begin
            if (i < m) begin
                if (k[i]) p = p ^ x[15:0];
                x = x << 1;
                if (x[m]) x = x ^ poly;
            end
        end
        return p;
    endfunction

    // alpha^e, evaluated at elaboration time for the Horner constants.
    function automatic logic [15:0] gf_pow(
        input logic [15:0] alpha,
        input int          e,
        input int          m,
        input logic [16:0] poly
    );
        logic [15:0] r;
        r = 16'd1;
        for (int i = 0; i < e; i++) r = gf_mul_const(r, alpha, m, poly);
        return r;
    endfunction

endpackage

// File: rtl/gf_const_mul.sv
// Combinational multiply of an M-bit field element by a fixed
// constant K in GF(2^M); synthesises to XOR gates only.
module gf_const_mul
    import rs_pkg::*;
#(
    parameter int         M         = RS_M,
    parameter logic [M:0] PRIM_POLY = RS_PRIM_POLY,
    parameter logic [M-1:0] K       = 1
) (
    input  logic [M-1:0] a,
    output logic [M-1:0] y
);

    assign y = M'(gf_mul_const(16'(a), 16'(K), M, 17'(PRIM_POLY)));

endmodule

// File: rtl/rs_syndrome_stream.sv
// Streaming Horner-rule syndrome calculator: one received symbol per
// cycle in, 2T syndromes per codeword out with valid/ready handshake.
module rs_syndrome_stream
    import rs_pkg::*;
#(
    parameter int         M         = RS_M,
    parameter int         N         = RS_N,
    parameter int         T         = RS_T,
    parameter logic [M:0] PRIM_POLY = RS_PRIM_POLY,
    parameter int         FCR       = RS_FCR
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [M-1:0]      in_sym,
    output logic              syn_valid,
    input  logic              syn_ready,
    output logic [2*T*M-1:0]  syn,
    output logic              syn_zero
);

    localparam int NSYN = 2 * T;
    localparam int CW   = $clog2(N + 1);

    logic [CW-1:0]                cnt;
    logic [NSYN-1:0][M-1:0]       acc;
    logic [NSYN-1:0][M-1:0]       prod;
    logic [NSYN-1:0][M-1:0]       nxt;
    logic [NSYN-1:0][M-1:0]       syn_q;
    logic                         last;
    logic                         accept;
    logic                         load;

    assign last     = (cnt == CW'(N - 1));
    // Only the final symbol of a codeword can stall, and only while an
    // earlier result is still waiting downstream.
    assign in_ready = !(last && syn_valid && !syn_ready);
    assign accept   = in_valid && in_ready;
    assign load     = accept && last;
    assign syn      = syn_q;

    for (genvar j = 0; j < NSYN; j++) begin : g_syn
        localparam logic [M-1:0] K =
            M'(gf_pow(16'd2, FCR + j, M, 17'(PRIM_POLY)));

        gf_const_mul #(
            .M         (M),
            .PRIM_POLY (PRIM_POLY),
            .K         (K)
        ) u_mul (
            .a (acc[j]),
            .y (prod[j])
        );

        assign nxt[j] = (cnt == '0) ? in_sym : (prod[j] ^ in_sym);
    end

    // Symbol counter, Horner accumulators and result register.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt       <= '0;
            acc       <= '0;
            syn_q     <= '0;
            syn_valid <= 1'b0;
            syn_zero  <= 1'b0;
        end else begin
            if (accept) begin
                acc <= nxt;
                cnt <= last ? '0 : cnt + CW'(1);
            end
            if (load) begin
                syn_q     <= nxt;
                syn_zero  <= (nxt == '0);
                syn_valid <= 1'b1;
            end else if (syn_valid && syn_ready) begin
                syn_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_rs_syndrome_stream.sv
// Directed self-checking bench for rs_syndrome_stream in the default
// RS(15,13) over GF(16) configuration.
module tb_rs_syndrome_stream;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] in_sym;
    logic       syn_valid;
    logic       syn_ready;
    logic [7:0] syn;
    logic       syn_zero;

    int checks = 0;
    int errors = 0;

    rs_syndrome_stream dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_sym    (in_sym),
        .syn_valid (syn_valid),
        .syn_ready (syn_ready),
        .syn       (syn),
        .syn_zero  (syn_zero)
    );

    always #5 clk = ~clk;

    // Stream w[14] first down to w[0]; called and returns at a negedge.
    task automatic send_word(input logic [14:0][3:0] w);
        for (int i = 14; i >= 0; i--) begin
            in_valid = 1'b1;
            in_sym   = w[i];
            @(negedge clk);
        end
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        in_valid = 1'b0;
        in_sym   = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        syn_ready = 1'b1;
        do_reset();
        checks++;
        if (in_ready !== 1'b1 || syn_valid !== 1'b0 ||
            syn !== 8'h00 || syn_zero !== 1'b0) begin
            errors++;
            $display("FAIL reset: rdy=%b v=%b syn=%h z=%b want 1 0 00 0",
                     in_ready, syn_valid, syn, syn_zero);
        end
    endtask

    task automatic test_single(input string nm,
                               input logic [14:0][3:0] w,
                               input logic [7:0] exp_syn,
                               input logic exp_zero);
        syn_ready = 1'b1;
        send_word(w);
        in_valid = 1'b0;
        checks++;
        if (syn_valid !== 1'b1 || syn !== exp_syn || syn_zero !== exp_zero) begin
            errors++;
            $display("FAIL %s: v=%b syn=%h z=%b want 1 %h %b",
                     nm, syn_valid, syn, syn_zero, exp_syn, exp_zero);
        end
        @(negedge clk);
        checks++;
        if (syn_valid !== 1'b0 || syn !== exp_syn) begin
            errors++;
            $display("FAIL %s_pulse: v=%b syn=%h want 0 %h",
                     nm, syn_valid, syn, exp_syn);
        end
    endtask

    task automatic test_back_to_back();
        logic [14:0][3:0] a;
        logic [14:0][3:0] b;
        int rdy_low;
        a = '0; a[0] = 4'd1;
        b = '0; b[1] = 4'd1;
        syn_ready = 1'b1;
        rdy_low = 0;
        for (int i = 0; i < 30; i++) begin
            in_valid = 1'b1;
            in_sym   = (i < 15) ? a[14 - i] : b[29 - i];
            if (in_ready !== 1'b1) rdy_low++;
            if (i == 15) begin
                checks++;
                if (syn_valid !== 1'b1 || syn !== 8'h11) begin
                    errors++;
                    $display("FAIL b2b_first: v=%b syn=%h want 1 11",
                             syn_valid, syn);
                end
            end
            if (i == 16) begin
                checks++;
                if (syn_valid !== 1'b0) begin
                    errors++;
                    $display("FAIL b2b_gap: v=%b want 0", syn_valid);
                end
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
        checks++;
        if (syn_valid !== 1'b1 || syn !== 8'h42) begin
            errors++;
            $display("FAIL b2b_second: v=%b syn=%h want 1 42", syn_valid, syn);
        end
        checks++;
        if (rdy_low !== 0) begin
            errors++;
            $display("FAIL b2b_ready: low cycles=%0d want 0", rdy_low);
        end
        @(negedge clk);
    endtask

    task automatic test_backpressure();
        logic [14:0][3:0] a;
        logic [14:0][3:0] b;
        int bad;
        a = '0; a[0] = 4'd1;
        b = '0; b[1] = 4'd1;
        syn_ready = 1'b0;
        send_word(a);
        bad = 0;
        for (int i = 14; i >= 1; i--) begin
            in_valid = 1'b1;
            in_sym   = b[i];
            if (in_ready !== 1'b1 || syn_valid !== 1'b1 || syn !== 8'h11) bad++;
            @(negedge clk);
        end
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL bp_accum: bad cycles=%0d want 0", bad);
        end
        in_sym = b[0];
        repeat (3) @(negedge clk);
        checks++;
        if (in_ready !== 1'b0 || syn_valid !== 1'b1 || syn !== 8'h11) begin
            errors++;
            $display("FAIL bp_stall: rdy=%b v=%b syn=%h want 0 1 11",
                     in_ready, syn_valid, syn);
        end
        syn_ready = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_release: rdy=%b want 1", in_ready);
        end
        @(negedge clk);
        in_valid = 1'b0;
        checks++;
        if (syn_valid !== 1'b1 || syn !== 8'h42) begin
            errors++;
            $display("FAIL bp_reload: v=%b syn=%h want 1 42", syn_valid, syn);
        end
        @(negedge clk);
        checks++;
        if (syn_valid !== 1'b0) begin
            errors++;
            $display("FAIL bp_drain: v=%b want 0", syn_valid);
        end
    endtask

    task automatic test_mid_reset();
        logic [14:0][3:0] a;
        int early;
        for (int i = 0; i < 7; i++) begin
            in_valid = 1'b1;
            in_sym   = 4'd5;
            @(negedge clk);
        end
        do_reset();
        checks++;
        if (syn_valid !== 1'b0 || syn !== 8'h00 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL midrst_state: v=%b syn=%h rdy=%b want 0 00 1",
                     syn_valid, syn, in_ready);
        end
        a = '0; a[0] = 4'd1;
        early = 0;
        for (int i = 14; i >= 0; i--) begin
            in_valid = 1'b1;
            in_sym   = a[i];
            if (syn_valid !== 1'b0) early++;
            @(negedge clk);
        end
        in_valid = 1'b0;
        checks++;
        if (early !== 0 || syn_valid !== 1'b1 || syn !== 8'h11 ||
            syn_zero !== 1'b0) begin
            errors++;
            $display("FAIL midrst_word: early=%0d v=%b syn=%h z=%b want 0 1 11 0",
                     early, syn_valid, syn, syn_zero);
        end
        @(negedge clk);
        syn_ready = 1'b0;
        send_word(a);
        in_valid = 1'b0;
        do_reset();
        syn_ready = 1'b1;
        checks++;
        if (syn_valid !== 1'b0 || syn !== 8'h00 || syn_zero !== 1'b0) begin
            errors++;
            $display("FAIL pend_reset: v=%b syn=%h z=%b want 0 00 0",
                     syn_valid, syn, syn_zero);
        end
    endtask

    initial begin
        logic [14:0][3:0] w;
        in_valid  = 1'b0;
        in_sym    = '0;
        syn_ready = 1'b1;
        rst       = 1'b1;
        test_reset();
        w = '0;
        test_single("all_zero", w, 8'h00, 1'b1);
        w = '0; w[0] = 4'd1;
        test_single("r0_one", w, 8'h11, 1'b0);
        w = '0; w[1] = 4'd1;
        test_single("r1_one", w, 8'h42, 1'b0);
        w = '0; w[14] = 4'd1;
        test_single("r14_one", w, 8'hd9, 1'b0);
        w = '0; w[0] = 4'd1; w[1] = 4'd1;
        test_single("r01_one", w, 8'h53, 1'b0);
        w = '0; w[2] = 4'd1; w[1] = 4'd6; w[0] = 4'd8;
        test_single("gen_poly", w, 8'h00, 1'b1);
        test_back_to_back();
        test_backpressure();
        test_mid_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
